// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: driver states, TAP path and the fixed
// TMS walks used to move the TAP between Run-Test/Idle and Shift.
package jtag_pkg;

  typedef enum logic [2:0] {
    RST_SEQ,
    IDLE,
    PRE,
    SHIFT,
    POST,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    PATH_NONE,
    PATH_DR,
    PATH_IR
  } path_e;

  localparam logic [2:0] TLR_CYCLES = 3'd5;

  // TMS walks, MSB is driven first
  localparam logic [2:0] DR_PRE_TMS = 3'b100;
  localparam logic [3:0] IR_PRE_TMS = 4'b1100;
  localparam logic [1:0] POST_TMS   = 2'b10;

  function automatic logic pre_last(
    input path_e      p,
    input logic [2:0] seq
  );
    return (p == PATH_IR) ? (seq == 3'd3)
                          : (seq == 3'd2);
  endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// TDI send register (parallel load, shift right) and TDO capture
// register written bit-by-bit at the current shift index.
module jtag_shift_reg #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               load,
  input  logic [MAX_LEN-1:0] load_data,
  input  logic               shift_en,
  input  logic               cap_en,
  input  logic [LEN_W-1:0]   cap_idx,
  input  logic               cap_bit,
  output logic               tx_bit,
  output logic [MAX_LEN-1:0] rx_data
);

  localparam logic [MAX_LEN-1:0] ONE = MAX_LEN'(1);

  logic [MAX_LEN-1:0] tx_q, tx_d;
  logic [MAX_LEN-1:0] rx_q, rx_d;
  logic [MAX_LEN-1:0] cap_mask;

  always_comb begin
    tx_d     = tx_q;
    rx_d     = rx_q;
    cap_mask = ONE << cap_idx;
    if (load) begin
      tx_d = load_data;
      rx_d = '0;
    end else begin
      if (shift_en) begin
        tx_d = tx_q >> 1;
      end
      if (cap_en) begin
        rx_d = cap_bit ? (rx_q | cap_mask)
                       : (rx_q & ~cap_mask);
      end
    end
  end

  always_ff @(posedge tck) begin
    if (!trst) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

  assign tx_bit  = tx_q[0];
  assign rx_data = rx_q;

endmodule

// File: rtl/jtag_driver.sv
// JTAG master: turns IR/DR shift commands into registered TMS/TDI
// sequences and returns the captured TDO bits as a response.
module jtag_driver
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

  state_e             state_q, state_d;
  path_e              path_q, path_d;
  logic [2:0]         seq_q, seq_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               err_q, err_d;

  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;

  logic               load, shift_en, cap_en;
  logic               tx_bit;
  logic [MAX_LEN-1:0] rx_data;
  logic [LEN_W-1:0]   len_m1;
  logic [2:0]         dr_sh;
  logic [3:0]         ir_sh;
  logic [1:0]         post_sh;

  assign len_m1 = len_q - ONE_L;

  jtag_shift_reg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_sreg (
    .tck       (tck),
    .trst      (trst),
    .load      (load),
    .load_data (cmd_data),
    .shift_en  (shift_en),
    .cap_en    (cap_en),
    .cap_idx   (idx_q),
    .cap_bit   (tdo),
    .tx_bit    (tx_bit),
    .rx_data   (rx_data)
  );

  always_comb begin
    state_d  = state_q;
    path_d   = path_q;
    seq_d    = seq_q;
    idx_d    = idx_q;
    len_d    = len_q;
    err_d    = err_q;
    load     = 1'b0;
    shift_en = 1'b0;
    cap_en   = 1'b0;
    unique case (state_q)
      RST_SEQ: begin
        if (seq_q == TLR_CYCLES + 3'd1) begin
          state_d = IDLE;
          seq_d   = '0;
        end else begin
          seq_d = seq_q + 3'd1;
        end
      end
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          load  = 1'b1;
          len_d = cmd_len;
          seq_d = '0;
          idx_d = '0;
          if (cmd_len == '0 || cmd_len > MAX_L) begin
            err_d   = 1'b1;
            path_d  = PATH_NONE;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            path_d  = cmd_is_ir ? PATH_IR : PATH_DR;
            state_d = PRE;
          end
        end
      end
      PRE: begin
        if (pre_last(path_q, seq_q)) begin
          state_d  = SHIFT;
          idx_d    = '0;
          shift_en = 1'b1;
        end else begin
          seq_d = seq_q + 3'd1;
        end
      end
      SHIFT: begin
        cap_en = 1'b1;
        if (idx_q == len_m1) begin
          state_d = POST;
          seq_d   = '0;
        end else begin
          idx_d    = idx_q + ONE_L;
          shift_en = 1'b1;
        end
      end
      POST: begin
        if (seq_q == 3'd1) begin
          state_d = RESP;
        end else begin
          seq_d = 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        path_d  = PATH_NONE;
      end
      default: begin
        state_d = RST_SEQ;
        seq_d   = '0;
      end
    endcase
  end

  // Pins are registered from the next state, so state_q always
  // names the TAP cycle currently presented on tms/tdi.
  always_comb begin
    dr_sh       = DR_PRE_TMS << seq_d;
    ir_sh       = IR_PRE_TMS << seq_d;
    post_sh     = POST_TMS << seq_d;
    tms_d       = 1'b0;
    tdi_d       = 1'b0;
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = (state_d == RESP) && err_d;
    rsp_data_d  = '0;
    unique case (state_d)
      RST_SEQ: tms_d = (seq_d <= TLR_CYCLES);
      IDLE:    tms_d = 1'b0;
      PRE:     tms_d = (path_d == PATH_IR) ? ir_sh[3]
                                           : dr_sh[2];
      SHIFT: begin
        tms_d = (idx_d == len_m1);
        tdi_d = tx_bit;
      end
      POST:    tms_d = post_sh[1];
      RESP: begin
        if (!err_d) begin
          rsp_data_d = rx_data;
        end
      end
      default: tms_d = 1'b1;
    endcase
  end

  always_ff @(posedge tck) begin
    if (!trst) begin
      state_q     <= RST_SEQ;
      path_q      <= PATH_NONE;
      seq_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      path_q      <= path_d;
      seq_q       <= seq_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      err_q       <= err_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_driver.sv
// Directed bench for jtag_driver: reset walk, DR/IR scans, illegal
// lengths, reset mid-scan and back-to-back commands.
module tb_jtag_driver;

  logic        tck = 1'b0;
  logic        trst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_is_ir;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        tms;
  logic        tdi;
  logic        tdo;

  logic loop_en = 1'b0;
  logic tie_val = 1'b0;
  logic byp     = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 tck = ~tck;

  // one-bit bypass stand-in: TDO is TDI delayed by one TAP cycle
  always @(posedge tck) byp <= tdi;
  assign tdo = loop_en ? byp : tie_val;

  jtag_driver #(.MAX_LEN(32), .LEN_W(6)) dut (
    .tck       (tck),
    .trst      (trst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_is_ir (cmd_is_ir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp_tms;
    exp_tms = 6'b111110;
    trst = 1'b0;
    cmd_valid = 1'b0;
    cmd_is_ir = 1'b0;
    cmd_len = '0;
    cmd_data = '0;
    tick();
    tick();
    total++;
    if ({tms, tdi, cmd_ready, busy} !== 4'b1001) begin
      bad++;
      $display("FAIL rst_pins: got tms/tdi/rdy/busy=%b want 1001",
               {tms, tdi, cmd_ready, busy});
    end
    total++;
    if ({rsp_valid, rsp_err} !== 2'b00 || rsp_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_rsp: got v=%b e=%b d=%h want 0 0 0",
               rsp_valid, rsp_err, rsp_data);
    end
    trst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (tms !== exp_tms[5-c] || cmd_ready !== 1'b0 ||
          rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_seq c%0d: got tms=%b rdy=%b v=%b want %b 0 0",
                 c + 1, tms, cmd_ready, rsp_valid, exp_tms[5-c]);
      end
    end
    tick();
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || tms !== 1'b0) begin
      bad++;
      $display("FAIL rst_idle: got rdy=%b busy=%b tms=%b want 1 0 0",
               cmd_ready, busy, tms);
    end
  endtask

  task automatic test_dr_bypass();
    logic [12:0] exp_tms;
    logic [7:0]  exp_tdi;
    int          errs;
    exp_tms = 13'b1000000000110;
    exp_tdi = 8'b10100101;
    errs = 0;
    loop_en = 1'b1;
    cmd_valid = 1'b1;
    cmd_is_ir = 1'b0;
    cmd_len = 6'd8;
    cmd_data = 32'hA5;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      total++;
      if (tms !== exp_tms[13-c] || cmd_ready !== 1'b0 ||
          rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL dr_tms c%0d: got tms=%b rdy=%b v=%b want %b 0 0",
                 c, tms, cmd_ready, rsp_valid, exp_tms[13-c]);
      end
      if (c >= 4 && c <= 11) begin
        if (tdi !== exp_tdi[11-c]) errs++;
      end else if (tdi !== 1'b0) begin
        errs++;
      end
      tick();
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL dr_tdi: got %0d wrong tdi cycles want 0", errs);
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 ||
        rsp_data !== 32'h4A) begin
      bad++;
      $display("FAIL dr_rsp: got v=%b e=%b d=%h want 1 0 0000004a",
               rsp_valid, rsp_err, rsp_data);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL dr_end: got v=%b rdy=%b want 0 1",
               rsp_valid, cmd_ready);
    end
    loop_en = 1'b0;
  endtask

  task automatic test_ir();
    logic [9:0] exp_tms;
    logic [3:0] exp_tdi;
    int         errs;
    exp_tms = 10'b1100000110;
    exp_tdi = 4'b1100;
    errs = 0;
    tie_val = 1'b1;
    cmd_valid = 1'b1;
    cmd_is_ir = 1'b1;
    cmd_len = 6'd4;
    cmd_data = 32'h3;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      total++;
      if (tms !== exp_tms[10-c] || rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL ir_tms c%0d: got tms=%b v=%b want %b 0",
                 c, tms, rsp_valid, exp_tms[10-c]);
      end
      if (c >= 5 && c <= 8) begin
        if (tdi !== exp_tdi[8-c]) errs++;
      end else if (tdi !== 1'b0) begin
        errs++;
      end
      tick();
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL ir_tdi: got %0d wrong tdi cycles want 0", errs);
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 ||
        rsp_data !== 32'h0000000F) begin
      bad++;
      $display("FAIL ir_rsp: got v=%b e=%b d=%h want 1 0 0000000f",
               rsp_valid, rsp_err, rsp_data);
    end
    tick();
  endtask

  task automatic test_illegal(input logic [5:0] len);
    cmd_valid = 1'b1;
    cmd_is_ir = 1'b0;
    cmd_len = len;
    cmd_data = 32'hDEADBEEF;
    tick();
    cmd_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 ||
        rsp_data !== 32'h0 || tms !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ill_rsp len%0d: got v=%b e=%b d=%h tms=%b busy=%b want 1 1 0 0 1",
               len, rsp_valid, rsp_err, rsp_data, tms, busy);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0 || tms !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ill_end len%0d: got v=%b tms=%b rdy=%b want 0 0 1",
               len, rsp_valid, tms, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp_tms;
    int         seen;
    exp_tms = 6'b111110;
    seen = 0;
    tie_val = 1'b0;
    cmd_valid = 1'b1;
    cmd_is_ir = 1'b0;
    cmd_len = 6'd16;
    cmd_data = 32'hFFFF;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    trst = 1'b0;
    tick();
    total++;
    if (tms !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 ||
        busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst: got tms=%b v=%b rdy=%b busy=%b want 1 0 0 1",
               tms, rsp_valid, cmd_ready, busy);
    end
    trst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid === 1'b1) seen++;
      total++;
      if (tms !== exp_tms[5-c] || cmd_ready !== 1'b0) begin
        bad++;
        $display("FAIL mid_seq c%0d: got tms=%b rdy=%b want %b 0",
                 c + 1, tms, cmd_ready, exp_tms[5-c]);
      end
    end
    tick();
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_idle: got rdy=%b want 1", cmd_ready);
    end
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid === 1'b1) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL mid_norsp: got %0d rsp pulses want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int   p1;
    int   p2;
    int   pulses;
    int   derr;
    logic rdy8;
    p1 = 0;
    p2 = 0;
    pulses = 0;
    derr = 0;
    rdy8 = 1'b0;
    tie_val = 1'b1;
    cmd_valid = 1'b1;
    cmd_is_ir = 1'b0;
    cmd_len = 6'd1;
    cmd_data = 32'h1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 8) rdy8 = cmd_ready;
      if (rsp_valid === 1'b1) begin
        pulses++;
        if (rsp_data !== 32'h1 || rsp_err !== 1'b0) derr++;
        if (p1 == 0) begin
          p1 = n;
        end else if (p2 == 0) begin
          p2 = n;
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    total++;
    if (p1 != 7) begin
      bad++;
      $display("FAIL b2b_first: got cycle %0d want 7", p1);
    end
    total++;
    if (p2 != 15) begin
      bad++;
      $display("FAIL b2b_second: got cycle %0d want 15", p2);
    end
    total++;
    if (rdy8 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready: got rdy=%b at cycle 8 want 1", rdy8);
    end
    total++;
    if (pulses != 2 || derr != 0) begin
      bad++;
      $display("FAIL b2b_rsp: got pulses=%0d derr=%0d want 2 0",
               pulses, derr);
    end
  endtask

  initial begin
    test_reset();
    test_dr_bypass();
    test_ir();
    test_illegal(6'd0);
    test_illegal(6'd33);
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_driver.md
Name: jtag_driver

Overview:
- Synchronous JTAG master that sits directly upstream of the JTAG top (TAP + data registers) and drives its tms/tdi, sampling its tdo.
- Converts "shift IR" / "shift DR" commands into exact TMS/TDI sequences, returning captured TDO bits as a response.
- Replaces hand-written tms_vector stimulus in benches and is the seed of an on-chip debug front end.

Parameters:
- MAX_LEN, 32, maximum shift length in bits.
- LEN_W, 6, width of cmd_len; must satisfy 2**LEN_W > MAX_LEN.

Ports:
- tck  input  1  clock; all logic on posedge.
- trst  input  1  reset; synchronous, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  driver idle and able to accept.
- cmd_is_ir  input  1  1 = IR scan, 0 = DR scan.
- cmd_len  input  LEN_W  number of bits to shift, 1..MAX_LEN.
- cmd_data  input  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  output  1  one-cycle pulse; response fields valid.
- rsp_data  output  MAX_LEN  captured TDO bits (bit i = i-th shifted); bits >= len are 0.
- rsp_err  output  1  command rejected (illegal length); qualified by rsp_valid.
- busy  output  1  not in IDLE.
- tms  output  1  registered, to TAP.
- tdi  output  1  registered, to TAP.
- tdo  input  1  from TAP; sampled on posedge.

Behaviour:
- Reset (trst=0 at a posedge), register values:
  - tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=1, state=RST_SEQ, counter=0.
  - Reset asserted mid-command aborts it; no response is issued.
- States: RST_SEQ, IDLE, PRE, SHIFT, POST, RESP. A 2-bit TAP-path enum is kept alongside the states.
- Output timing: every state-dependent tms/tdi value is registered. The TAP consumes it at the following posedge, so one "TAP cycle" equals one tck of registered output.
- RST_SEQ:
  - Drive tms=1 for 5 cycles after reset release, then tms=0 for 1 cycle (TLR -> RTI).
  - Then go to IDLE. cmd_ready goes high on the 7th cycle after release.
- IDLE:
  - tms=0 (stay in RTI), tdi=0, cmd_ready=1, busy=0.
  - Accept on posedge with cmd_valid & cmd_ready. Latch is_ir, len and data.
  - If cmd_len==0 or cmd_len>MAX_LEN: no TAP traffic; go to RESP with rsp_err=1 and rsp_data=0.
- PRE:
  - DR path drives tms 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - IR path drives tms 1,1,0,0.
  - tdi=0 throughout.
- SHIFT:
  - len cycles; tdi = data[k] in cycle k.
  - tms=0 for k<len-1; tms=1 on the last bit (Shift -> Exit1).
  - tdo sampled at the posedge ending each shift cycle (the same edge the TAP shifts) and stored into bit k.
- POST: tms 1,0 (Exit1 -> Update -> RTI), tdi=0.
- RESP: rsp_valid=1 for exactly one cycle with rsp_data/rsp_err; then IDLE. There is no response backpressure.
- Totals from accept to rsp_valid:
  - DR: len+5 TAP cycles, then 1 RESP cycle.
  - IR: len+6 TAP cycles, then 1 RESP cycle.
- cmd_ready is 0 in every non-IDLE state. A held cmd_valid is accepted again on the first IDLE cycle after RESP.
- cmd_* inputs are ignored while not ready; latched copies are used for the whole command.
- Counters: one LEN_W-bit shift index and one 3-bit sequence counter; neither wraps within legal lengths.

Decomposition:
- Shared package jtag_pkg:
  - state enum (RST_SEQ..RESP);
  - TLR_CYCLES=5;
  - DR_PRE_TMS=3'b100, IR_PRE_TMS=4'b1100, POST_TMS=2'b10 (MSB first).
- The package is reused by the TAP and by the benches.
- Optional sub-module jtag_shift_reg (parameterised MAX_LEN parallel-load shift/capture register); the FSM stays in jtag_driver.

Test Plan:
- Reset sequence: release trst -> tms=1,1,1,1,1,0; cmd_ready rises on cycle 7; rsp_valid stays 0.
- DR scan, len=8, data=0xA5, tdo looped to tdi via the JTAG top bypass:
  - tms = 1,0,0,0,0,0,0,0,0,0,1,1,0 (13 cycles);
  - tdi in shift cycles = 1,0,1,0,0,1,0,1;
  - rsp_valid on cycle 14; rsp_data = bypass-delayed pattern 0x4A.
- IR scan, len=4, data=0x3, tdo tied 1:
  - tms = 1,1,0,0,0,0,0,1,1,0;
  - rsp_data=0x0000000F, rsp_err=0.
- Illegal len:
  - cmd_len=0 -> rsp_valid next-but-one cycle, rsp_err=1, tms stays 0 throughout;
  - same for cmd_len=33.
- Reset mid-shift:
  - assert trst during SHIFT of a len=16 DR -> tms=1 next cycle, no rsp_valid;
  - 5x tms=1 then tms=0 after release.
- Back-to-back: cmd_valid held for two DR len=1 commands -> second accepted on the first IDLE cycle after RESP; two rsp_valid pulses 8 cycles apart.
